pipeline_fetch_queue: RTL
=========================

// Module: pipeline_fetch_queue
// PURPOSE
// Instruction fetch stage feeding the IF/ID register of the 5-stage pipeline CPU.
// - Generates the fetch PC, drives it to instruction memory, buffers {pc, instruction} pairs in a small FIFO.
// - Hands entries to the decode stage through a valid/ready handshake.
// - Lets decode stall without losing fetched work.
// - A taken-branch redirect from decode flushes the buffer and restarts fetch at the target.
// PARAMETERS
// DEPTH   4   queue entries; power of two, >= 2
// CW      3   occupancy width, $clog2(DEPTH+1)
// PORTS
// clk          in   1    system clock, all state on posedge
// reset        in   1    synchronous, active-high
// imem_addr    out  64   fetch PC to instruction memory (combinational read)
// imem_instr   in   32   instruction at imem_addr, valid in the same cycle
// redirect     in   1    branch taken in ID; flush queue and reload fetch PC
// redirect_pc  in   64   branch target (PC_ID + offset<<2)
// id_ready     in   1    decode accepts head entry this cycle
// id_valid     out  1    head entry valid
// id_instr     out  32   head instruction; 32'h0 when id_valid=0
// id_pc        out  64   PC of head instruction; 64'h0 when id_valid=0
// count        out  CW   current occupancy, 0..DEPTH
// BEHAVIOUR
// - Reset, checked at clk edge:
//   - fetch_pc=0, rd_ptr=wr_ptr=0, count=0.
//   - Outputs: imem_addr=0, id_valid=0, id_instr=0, id_pc=0.
//   - Reset asserted mid-stream discards all entries and overrides redirect.
// - imem_addr = fetch_pc at all times; fetch_pc is always word aligned.
// - pop  = id_valid & id_ready.
// - push = ~redirect & ((count < DEPTH) | pop). Push writes {fetch_pc, imem_instr} at wr_ptr.
// - On push: fetch_pc <= fetch_pc + 4, mod 2^64 (wraps, no flag). Otherwise fetch_pc holds.
// - Occupancy:
//   - push & ~pop: count+1
//   - pop & ~push: count-1
//   - both: unchanged. At full with pop, the freed slot is refilled in the same cycle.
// - rd_ptr and wr_ptr advance modulo DEPTH on pop and push respectively.
// - id_valid = (count != 0). id_instr and id_pc come from the storage entry at rd_ptr, muxed to 0 when empty.
// - Latency: an instruction pushed at edge N is visible at the id_* outputs after edge N.
//   - Entering an empty queue: 1 cycle to ID.
// - Redirect (priority over push/pop, below reset):
//   - At the edge: count<=0 and rd_ptr<=wr_ptr.
//   - fetch_pc <= {redirect_pc[63:2], 2'b00}.
//   - The same-cycle pop is still treated as consumed by ID; the same-cycle push is dropped.
//   - The first target instruction is valid one cycle after the redirect edge.
// - id_ready is ignored while id_valid=0.
// - Holding id_ready=0 keeps all id_* outputs stable.
// - Full & ~id_ready: fetch stalls, with imem_addr held at the next unfetched PC.
// - No combinational path from id_ready or redirect to imem_addr.
//   - imem_addr depends only on registered fetch_pc.
// TESTING
// 1. Reset for 2 cycles, release, id_ready=1, imem returns addr-derived words.
//    -> id_pc sequence 0,4,8,12,... one per cycle from cycle 2. count stays 1.
// 2. id_ready=0 from reset.
//    -> count 1,2,3,4 over 4 cycles, then imem_addr held at 16.
//    -> id_pc=0 stable. Raising id_ready then pops 0,4,8,12,16 back-to-back with count=4.
// 3. Queue full, redirect=1 with redirect_pc=0x103.
//    -> next cycle count=0, id_valid=0, imem_addr=0x100.
//    -> following cycle id_valid=1, id_pc=0x100.
// 4. redirect and id_ready=1 in the same cycle at count=2.
//    -> head popped once, no stale entries after the flush. Next valid id_pc = redirect target.
// 5. Wrap: run 3*DEPTH+1 push/pop cycles with random id_ready.
//    -> id_pc strictly +4 per pop, no duplicates or skips across the pointer wrap.
// 6. Reset pulsed mid-stream at count=3 with redirect=1.
//    -> after the edge count=0, imem_addr=0, id_valid=0. Redirect ignored.

Source files
------------

// File: rtl/pipeline_fetch_queue.sv
// ============================================================================
// Module   : pipeline_fetch_queue
// Brief    : Fetch PC generator with a small {pc, instr} FIFO feeding ID.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pipeline_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  output logic [63:0]   imem_addr,
  input  logic [31:0]   imem_instr,
  input  logic          redirect,
  input  logic [63:0]   redirect_pc,
  input  logic          id_ready,
  output logic          id_valid,
  output logic [31:0]   id_instr,
  output logic [63:0]   id_pc,
  output logic [CW-1:0] count
);

  localparam int            PTR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [CW-1:0] COUNT_ONE  = CW'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [63:0]   ALIGN_MASK = ~64'h3;

  logic [63:0]      fetch_pc_q, fetch_pc_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  logic [63:0] pc_mem_q    [DEPTH];
  logic [31:0] instr_mem_q [DEPTH];

  logic w_valid;
  logic w_pop;
  logic w_push;

  always_comb begin
    w_valid = (count_q != '0);
    w_pop   = w_valid & id_ready;
    // A pop frees the slot in the same cycle, so a full queue can still accept.
    w_push  = ~redirect & ((count_q < FULL_COUNT) | w_pop);
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;

    if (redirect) begin
      fetch_pc_d = redirect_pc & ALIGN_MASK;
      rd_ptr_d   = wr_ptr_q;
      count_d    = '0;
    end else begin
      if (w_push) begin
        fetch_pc_d = fetch_pc_q + 64'd4;
        wr_ptr_d   = wr_ptr_q + PTR_ONE;
      end
      if (w_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      if (w_push && !w_pop) begin
        count_d = count_q + COUNT_ONE;
      end else if (w_pop && !w_push) begin
        count_d = count_q - COUNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // Payload needs no reset: outputs are gated by occupancy.
  always_ff @(posedge clk) begin
    if (w_push) begin
      pc_mem_q[wr_ptr_q]    <= fetch_pc_q;
      instr_mem_q[wr_ptr_q] <= imem_instr;
    end
  end

  always_comb begin
    imem_addr = fetch_pc_q;
    id_valid  = w_valid;
    count     = count_q;
    id_pc     = w_valid ? pc_mem_q[rd_ptr_q]    : 64'h0;
    id_instr  = w_valid ? instr_mem_q[rd_ptr_q] : 32'h0;
  end

endmodule

`default_nettype wire
